spim_avbreg: RTL and testbench

SPIM_AVBREG -- requirements
Module: spim_avbreg

---
 rtl/spim_avbreg.sv | 196 +++++++++++++++++++
 tb/tb_spim_avbreg.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spim_avbreg.sv
// Register front-end between an AVMM bridge and a SPI master engine: command word,
// sticky status, and host/engine shared write and read buffers.
`timescale 1ns/1ps
module spim_avbreg #(
  parameter  int BUF_DEPTH = 16,
  localparam int AW        = $clog2(BUF_DEPTH)
) (
  input  logic          m_avmm_clk,
  input  logic          m_avmm_rst_n,
  input  logic [15:0]   avbreg_addr,
  input  logic [3:0]    avbbyte_en,
  input  logic [31:0]   avbreg_wdata,
  input  logic          avbreg_write,
  input  logic          avbreg_read,
  output logic [31:0]   avbreg_rdata,
  output logic          avbreg_waitreq,
  output logic          avbreg_rdatavld,
  output logic [31:0]   cmd_word,
  output logic          cmd_start,
  input  logic          spi_busy,
  input  logic          spi_done,
  input  logic [AW-1:0] wbuf_raddr,
  output logic [31:0]   wbuf_rdata,
  input  logic          rbuf_we,
  input  logic [AW-1:0] rbuf_waddr,
  input  logic [31:0]   rbuf_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RVLD} state_e;
  typedef enum logic [2:0] {T_NONE, T_CMD, T_STAT, T_WBUF, T_RBUF} tgt_e;

  localparam logic [13:0] WBUF_BASE = 14'h0080;
  localparam logic [13:0] RBUF_BASE = 14'h0100;

  function automatic tgt_e decode(input logic [13:0] wa);
    tgt_e t;
    t = T_NONE;
    if (wa == 14'h0000)                         t = T_CMD;
    else if (wa == 14'h0001)                    t = T_STAT;
    else if (wa[13:AW] == WBUF_BASE[13:AW])     t = T_WBUF;
    else if (wa[13:AW] == RBUF_BASE[13:AW])     t = T_RBUF;
    return t;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [13:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cmd_q, cmd_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] wbuf_q [BUF_DEPTH];
  logic [31:0] wbuf_d [BUF_DEPTH];
  logic [31:0] rbuf_q [BUF_DEPTH];
  logic [31:0] rbuf_d [BUF_DEPTH];

  logic [13:0] live_waddr;
  logic [31:0] rd_mux;
  logic [31:0] status_word;
  logic        commit;
  tgt_e        commit_tgt;
  logic        cmd_wr, stat_wr, wbuf_wr;
  logic [31:0] wbuf_merged;
  logic [BUF_DEPTH-1:0] wbuf_we;
  logic        unused_addr_lsb;

  assign live_waddr      = avbreg_addr[15:2];
  assign unused_addr_lsb = ^avbreg_addr[1:0];
  assign status_word     = {29'd0, err_q, done_q, spi_busy};

  // Read data is sampled from the live request while still in IDLE.
  always_comb begin
    rd_mux = '0;
    unique case (decode(live_waddr))
      T_CMD:   rd_mux = cmd_q;
      T_STAT:  rd_mux = status_word;
      T_WBUF:  rd_mux = wbuf_q[live_waddr[AW-1:0]];
      T_RBUF:  rd_mux = rbuf_q[live_waddr[AW-1:0]];
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (avbreg_write || avbreg_read) begin
          state_d = S_ACK;
          wr_d    = avbreg_write;
          waddr_d = live_waddr;
          be_d    = avbbyte_en;
          wdata_d = avbreg_wdata;
          if (!avbreg_write) rdata_d = rd_mux;
        end
      end
      S_ACK: begin
        commit  = wr_q;
        state_d = wr_q ? S_IDLE : S_RVLD;
      end
      S_RVLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit_tgt = decode(waddr_q);
  assign cmd_wr     = commit && (commit_tgt == T_CMD);
  assign stat_wr    = commit && (commit_tgt == T_STAT) && be_q[0];
  assign wbuf_wr    = commit && (commit_tgt == T_WBUF);

  // A command write while the engine is busy is refused and flagged instead.
  always_comb begin
    cmd_d   = cmd_q;
    start_d = 1'b0;
    if (cmd_wr && !spi_busy) begin
      cmd_d   = be_merge(cmd_q, wdata_q, be_q);
      start_d = 1'b1;
    end
    err_d  = (cmd_wr && spi_busy) || (err_q && !(stat_wr && wdata_q[2]));
    done_d = spi_done || (done_q && !(stat_wr && wdata_q[1]));
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_wbuf_we
    assign wbuf_we[gi] = wbuf_wr && (waddr_q[AW-1:0] == AW'(gi));
  end

  assign wbuf_merged = be_merge(wbuf_q[waddr_q[AW-1:0]], wdata_q, be_q);

  always_comb begin
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (wbuf_we[i]) wbuf_d[i] = wbuf_merged;
    end
    if (rbuf_we) rbuf_d[rbuf_waddr] = rbuf_wdata;
  end

  always_ff @(posedge m_avmm_clk or negedge m_avmm_rst_n) begin
    if (!m_avmm_rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cmd_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        wbuf_q[i] <= '0;
        rbuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign avbreg_rdata    = rdata_q;
  assign avbreg_waitreq  = (state_q != S_ACK);
  assign avbreg_rdatavld = (state_q == S_RVLD);
  assign cmd_word        = cmd_q;
  assign cmd_start       = start_q;
  assign wbuf_rdata      = wbuf_q[wbuf_raddr];

endmodule

// File: tb/tb_spim_avbreg.sv
// Directed bench for spim_avbreg: a vector table of host accesses plus hand-built
// sequences for command start, busy refusal, W1C races, engine buffers and reset.
`timescale 1ns/1ps
module tb_spim_avbreg;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NV    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   avbreg_addr = '0;
  logic [3:0]    avbbyte_en = '0;
  logic [31:0]   avbreg_wdata = '0;
  logic          avbreg_write = 1'b0;
  logic          avbreg_read = 1'b0;
  logic [31:0]   avbreg_rdata;
  logic          avbreg_waitreq;
  logic          avbreg_rdatavld;
  logic [31:0]   cmd_word;
  logic          cmd_start;
  logic          spi_busy = 1'b0;
  logic          spi_done = 1'b0;
  logic [AW-1:0] wbuf_raddr = '0;
  logic [31:0]   wbuf_rdata;
  logic          rbuf_we = 1'b0;
  logic [AW-1:0] rbuf_waddr = '0;
  logic [31:0]   rbuf_wdata = '0;

  spim_avbreg #(.BUF_DEPTH(DEPTH)) dut (
    .m_avmm_clk      (clk),
    .m_avmm_rst_n    (rst_n),
    .avbreg_addr     (avbreg_addr),
    .avbbyte_en      (avbbyte_en),
    .avbreg_wdata    (avbreg_wdata),
    .avbreg_write    (avbreg_write),
    .avbreg_read     (avbreg_read),
    .avbreg_rdata    (avbreg_rdata),
    .avbreg_waitreq  (avbreg_waitreq),
    .avbreg_rdatavld (avbreg_rdatavld),
    .cmd_word        (cmd_word),
    .cmd_start       (cmd_start),
    .spi_busy        (spi_busy),
    .spi_done        (spi_done),
    .wbuf_raddr      (wbuf_raddr),
    .wbuf_rdata      (wbuf_rdata),
    .rbuf_we         (rbuf_we),
    .rbuf_waddr      (rbuf_waddr),
    .rbuf_wdata      (rbuf_wdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;

  always @(negedge clk) if (cmd_start === 1'b1) start_cnt++;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic host_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    int low;
    low = 0;
    @(negedge clk);
    avbreg_addr = a; avbbyte_en = be; avbreg_wdata = d; avbreg_write = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (!avbreg_waitreq) begin low = i; break; end
    end
    @(negedge clk);
    avbreg_write = 1'b0;
    $display("WR addr=%04h be=%h data=%08h accept_cyc=%0d", a, be, d, low);
    check("wr_accept_cyc", 32'(low), 32'd1);
    check("wr_waitreq_after", 32'(avbreg_waitreq), 32'd1);
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d);
    int  vc;
    bit  acc;
    vc = 0; acc = 1'b0; d = 'x;
    @(negedge clk);
    avbreg_addr = a; avbreg_read = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (acc) avbreg_read = 1'b0;
      if (!avbreg_waitreq) acc = 1'b1;
      if (avbreg_rdatavld) begin d = avbreg_rdata; vc = i; break; end
    end
    avbreg_read = 1'b0;
    $display("RD addr=%04h data=%08h vld_cyc=%0d", a, d, vc);
    check("rd_vld_cyc", 32'(vc), 32'd2);
    @(negedge clk);
    check("rd_vld_drop", 32'(avbreg_rdatavld), 32'd0);
    check("rd_data_hold", avbreg_rdata, d);
  endtask

  task automatic read_expect(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] r;
    host_read(a, r);
    check(name, r, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          s;

    vecs[0]  = '{1'b1, 16'h0200, 4'hF, 32'hA5A5_1234, 32'h0};
    vecs[1]  = '{1'b0, 16'h0200, 4'h0, 32'h0,         32'hA5A5_1234};
    vecs[2]  = '{1'b1, 16'h0204, 4'h5, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b0, 16'h0204, 4'h0, 32'h0,         32'h0022_0044};
    vecs[4]  = '{1'b1, 16'h0206, 4'hA, 32'hAABB_CCDD, 32'h0};
    vecs[5]  = '{1'b0, 16'h0204, 4'h0, 32'h0,         32'hAA22_CC44};
    vecs[6]  = '{1'b1, 16'h023C, 4'hF, 32'h0000_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 16'h023C, 4'h0, 32'h0,         32'h0000_BEEF};
    vecs[8]  = '{1'b1, 16'h0240, 4'hF, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, 16'h0240, 4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 16'h0200, 4'h0, 32'h0,         32'hA5A5_1234};
    vecs[11] = '{1'b1, 16'h0400, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 16'h0400, 4'h0, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 16'h0800, 4'h0, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 16'h0004, 4'h0, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 16'h0000, 4'h0, 32'h0,         32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_waitreq", 32'(avbreg_waitreq), 32'd1);
    check("rst_rdatavld", 32'(avbreg_rdatavld), 32'd0);
    check("rst_rdata", avbreg_rdata, 32'h0);
    check("rst_cmd_word", cmd_word, 32'h0);
    check("rst_cmd_start", 32'(cmd_start), 32'd0);
    check("rst_wbuf0", wbuf_rdata, 32'h0);
    rst_n = 1'b1;

    // Vector table
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr) host_write(vecs[v].addr, vecs[v].be, vecs[v].wdata);
      else            read_expect("vec_rdata", vecs[v].addr, vecs[v].exp);
    end

    // Engine view of wrt_buf
    @(negedge clk); wbuf_raddr = 4'd0;  #1 check("eng_wbuf0", wbuf_rdata, 32'hA5A5_1234);
    @(negedge clk); wbuf_raddr = 4'd1;  #1 check("eng_wbuf1", wbuf_rdata, 32'hAA22_CC44);
    @(negedge clk); wbuf_raddr = 4'd15; #1 check("eng_wbuf15", wbuf_rdata, 32'h0000_BEEF);

    // Command start with engine idle
    s = start_cnt;
    host_write(16'h0000, 4'h1, 32'h0000_0081);
    check("cmd_word_81", cmd_word, 32'h0000_0081);
    check("cmd_start_hi", 32'(cmd_start), 32'd1);
    @(negedge clk);
    check("cmd_start_lo", 32'(cmd_start), 32'd0);
    #1 check("cmd_start_count", 32'(start_cnt - s), 32'd1);
    host_write(16'h0000, 4'h2, 32'h1234_56FF);
    check("cmd_word_be", cmd_word, 32'h0000_5681);
    read_expect("cmd_readback", 16'h0000, 32'h0000_5681);

    // Command refused while busy
    @(negedge clk); spi_busy = 1'b1;
    s = start_cnt;
    host_write(16'h0000, 4'hF, 32'hFFFF_FFFF);
    check("busy_cmd_start", 32'(cmd_start), 32'd0);
    check("busy_cmd_word", cmd_word, 32'h0000_5681);
    read_expect("busy_status", 16'h0004, 32'h0000_0005);
    #1 check("busy_start_count", 32'(start_cnt - s), 32'd0);
    @(negedge clk); spi_busy = 1'b0;
    read_expect("err_sticky", 16'h0004, 32'h0000_0004);
    host_write(16'h0004, 4'hE, 32'h0000_0006);
    read_expect("w1c_lane0_off", 16'h0004, 32'h0000_0004);
    host_write(16'h0004, 4'h1, 32'h0000_0004);
    read_expect("w1c_err_clear", 16'h0004, 32'h0000_0000);

    // Engine write of rd_buf, then host read
    @(negedge clk); rbuf_we = 1'b1; rbuf_waddr = 4'd3; rbuf_wdata = 32'hDEAD_0003;
    @(negedge clk); rbuf_we = 1'b0;
    read_expect("rbuf3", 16'h040C, 32'hDEAD_0003);

    // Host capture and engine write to the same word in one cycle
    fork
      host_read(16'h040C, rd);
      begin
        @(negedge clk); rbuf_we = 1'b1; rbuf_waddr = 4'd3; rbuf_wdata = 32'h1111_1111;
        @(negedge clk); rbuf_we = 1'b0;
      end
    join
    check("rbuf_race_old", rd, 32'hDEAD_0003);
    read_expect("rbuf_race_new", 16'h040C, 32'h1111_1111);

    // done sticky and W1C race
    @(negedge clk); spi_done = 1'b1;
    @(negedge clk); spi_done = 0;
    read_expect("done_set", 16'h0004, 32'h0000_0002);
    fork
      host_write(16'h0004, 4'h1, 32'h0000_0002);
      begin
        @(negedge clk); @(negedge clk); spi_done = 1'b1;
        @(negedge clk); spi_done = 1'b0;
      end
    join
    read_expect("done_race_wins", 16'h0004, 32'h0000_0002);
    host_write(16'h0004, 4'h1, 32'h0000_0002);
    read_expect("done_cleared", 16'h0004, 32'h0000_0000);

    // Reset asserted while a write sits in ACK
    @(negedge clk);
    avbreg_addr = 16'h0208; avbbyte_en = 4'hF; avbreg_wdata = 32'h5555_AAAA; avbreg_write = 1'b1;
    @(negedge clk);
    check("midrst_in_ack", 32'(avbreg_waitreq), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_waitreq", 32'(avbreg_waitreq), 32'd1);
    check("midrst_cmd_word", cmd_word, 32'h0);
    avbreg_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wbuf_raddr = 4'd2;
    #1 check("midrst_target", wbuf_rdata, 32'h0);
    check("midrst_rdata", avbreg_rdata, 32'h0);
    read_expect("midrst_host_target", 16'h0208, 32'h0);
    read_expect("midrst_wbuf0", 16'h0200, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
